sevenseg_scan: RTL
==================

# sevenseg_scan

Time-multiplexed seven-segment display driver for the clock system. It sits directly downstream of the 4-bit display PIO registers: each PIO `out_port` nibble arrives as one BCD/hex digit. The block latches all digits coherently once per frame, scans them across a common-segment display, and decodes each digit to segment patterns.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned, minimum 2.
- `SCAN_DIV`, default 50000: clk cycles per digit slot, minimum 2. At 50 MHz the default gives a 1 ms slot.
- `ACTIVE_LOW`, default 1: 1 means `seg` and `an` drive low to light; 0 means active high.
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `digit_val`  in  4*NUM_DIGITS  digit i is at bits [4i+3:4i]. Digit 0 is the rightmost (least significant).
- `digit_en`  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
- `seg`  out  7  segment drive {g,f,e,d,c,b,a}, registered.
- `an`  out  NUM_DIGITS  one-hot digit select, registered.
- `frame_tick`  out  1  one-cycle pulse when the shadow registers load.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps.
- On the edge where `pcnt == SCAN_DIV-1`, scan index `idx` advances. It wraps from NUM_DIGITS-1 to 0.
- Shadow registers `sh_val` and `sh_en` load from `digit_val` and `digit_en` in two cases:
  - on the edge where `pcnt == SCAN_DIV-1` and `idx == NUM_DIGITS-1` (frame boundary);
  - on the first clock edge after `reset_n` deasserts, tracked by a `primed` flag that reset clears.
- `frame_tick` is registered and is 1 for exactly the cycle following each load.
- Inputs are sampled only at loads. Changes mid-frame never appear until the next frame, so there is no tearing.
- Decode is hex. 0-9 map to standard digits; 10-15 map to A, b, C, d, E, F. Segment patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - These are active-high values, inverted when ACTIVE_LOW=1.
- A blanked digit drives all segments off while its `an` bit still follows the scan.
- Ghost guard: `an` is all-inactive in the first cycle of every slot (`pcnt == 0`). It is one-hot on `idx` for the remaining SCAN_DIV-1 cycles.
- State: `pcnt`, `idx`, `sh_val`, `sh_en`, `primed`, output registers. No other FSM.

## Timing
- Reset, synchronous while `reset_n == 0`:
  - `pcnt`=0, `idx`=0, `sh_en`=0, `sh_val`=0, `primed`=0;
  - `seg` all off, `an` all inactive, `frame_tick`=0.
- Outputs are registered with 1-cycle latency. `seg`/`an` in cycle n+1 reflect `pcnt`, `idx` and shadow in cycle n.
- Slot length is exactly SCAN_DIV cycles. Frame length is NUM_DIGITS*SCAN_DIV cycles.
- A frame-boundary load and an `idx` wrap occur on the same edge. The new values are displayed starting with digit 0.
- Reset asserted mid-scan aborts the frame immediately. The next frame starts from digit 0 with freshly loaded values.

## Configuration
- `SEVENSEG_LZB_EN` (leading-zero blanking) defined:
  - a digit with `sh_val == 0` is blanked when all higher-index digits are 0 or disabled;
  - digit 0 is never blanked by this rule;
  - the blank mask is computed at load time and stored with the shadow.
- Not defined: only `digit_en` blanks. Zeros display as "0".

## Structure
- Shared package `sevenseg_pkg` holds:
  - the 16-entry segment pattern constant array;
  - the `SEG_OFF` constant;
  - the `seg_t` (7-bit) typedef.
- Sub-module `sevenseg_decode`: combinational 4-bit value plus blank input to `seg_t`, with polarity applied by parameter.
- Top level holds the prescaler, scan counter, shadow/LZB logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset release with `digit_val`=16'h1234 and `digit_en`=4'hF:
  - `frame_tick` pulses once;
  - digit 0 slot shows `seg`=~7'h66 ("4") with `an`=4'b1110 in cycles 2-4 of the slot and 4'b1111 in cycle 1.
- Full sweep: `an` cycles 1110→1101→1011→0111 with period 4 and frame 16. The guard cycle is all-ones every slot.
- Mid-frame change of `digit_val` to 16'hABCD while `idx`=1: remaining slots still show 3,2,1. The next frame shows d,C,b,A and `frame_tick` pulses at the boundary.
- `digit_en`=4'b1010 with `digit_val`=16'h5678: slots 0 and 2 show `seg`=7'h7F (off); slots 1 and 3 show "7" and "5".
- With `SEVENSEG_LZB_EN`, `digit_val`=16'h0070 and `digit_en`=4'hF: digits 3 and 2 are blank, digit 1 shows "7", digit 0 shows "0". Without the macro: 0,0,7,0.
- `reset_n` low for 1 cycle at `pcnt`=2, `idx`=3: the next cycle has all outputs off, then the scan restarts at digit 0 with a reload.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment types and constants: hex segment table, blank pattern
// and a polarity helper. Patterns are active-high {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    localparam seg_t SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t seg_pol(input seg_t s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex digit to segment decoder with blanking; output polarity
// is fixed by ACTIVE_LOW.
module sevenseg_decode
    import sevenseg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] val_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    assign seg_o = seg_pol(blank_i ? SEG_OFF : SEG_LUT[val_i], ACTIVE_LOW);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scanner with per-frame shadow latch.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output seg_t                    seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]                 pcnt_q, pcnt_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]    sh_val_q;
    logic [NUM_DIGITS-1:0]         sh_en_q;
    logic                          primed_q;
    seg_t                          seg_q, seg_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d, an_onehot;
    logic                          tick_q;

    logic [NUM_DIGITS-1:0][3:0]    dval;
    logic                          slot_end, load, cur_blank;
    seg_t                          seg_dec;

    assign dval = digit_val;

    always_comb begin
        slot_end = (pcnt_q == PCNT_MAX);
        load     = !primed_q || (slot_end && idx_q == IDX_MAX);
        pcnt_d   = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end)
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

`ifdef SEVENSEG_LZB_EN
    // Blank mask is resolved at load so the scan only needs a lookup.
    logic [NUM_DIGITS-1:0] sh_lzb_q, lzb_d;

    always_comb begin
        logic hi_zero;
        hi_zero = 1'b1;
        lzb_d   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (hi_zero && dval[i] == 4'h0)
                lzb_d[i] = 1'b1;
            hi_zero = hi_zero && (dval[i] == 4'h0 || !digit_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            sh_lzb_q <= '0;
        else if (load)
            sh_lzb_q <= lzb_d;
    end

    assign cur_blank = !sh_en_q[idx_q] || sh_lzb_q[idx_q];
`else
    assign cur_blank = !sh_en_q[idx_q];
`endif

    sevenseg_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .val_i   (sh_val_q[idx_q]),
        .blank_i (cur_blank),
        .seg_o   (seg_dec)
    );

    // First cycle of each slot keeps every anode off to hide segment changes.
    always_comb begin
        an_onehot        = '0;
        an_onehot[idx_q] = 1'b1;
        an_d  = (pcnt_q == '0) ? AN_OFF : (ACTIVE_LOW ? ~an_onehot : an_onehot);
        seg_d = seg_dec;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt_q   <= '0;
            idx_q    <= '0;
            sh_val_q <= '0;
            sh_en_q  <= '0;
            primed_q <= 1'b0;
            seg_q    <= seg_pol(SEG_OFF, ACTIVE_LOW);
            an_q     <= AN_OFF;
            tick_q   <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            primed_q <= 1'b1;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= load;
            if (load) begin
                sh_val_q <= dval;
                sh_en_q  <= digit_en;
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
